// File: rtl/mcu_dispatch_pkg.sv
// Shared state encoding, target ids and helpers for the MCU byte dispatcher.
package mcu_dispatch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_ROUTE,
        ST_STAT,
        ST_DROP
    } state_t;

    localparam logic [7:0] TGT_SYS  = 8'h00;
    localparam logic [7:0] TGT_HID  = 8'h01;
    localparam logic [7:0] TGT_OSD  = 8'h02;
    localparam logic [7:0] TGT_SDC  = 8'h03;
    localparam logic [7:0] TGT_STAT = 8'hFF;

    function automatic logic [3:0] tgt_onehot(input logic [1:0] id);
        tgt_onehot = 4'b0001 << id;
    endfunction

endpackage

// File: rtl/mcu_dispatch_timer.sv
// Idle-cycle counter; expired holds once the count reaches TIMEOUT_CYCLES while enabled.
// Latency: count advances one per enabled cycle; no backpressure.
module mcu_dispatch_timer #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt;

    assign expired = enable && (cnt == LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mcu_dispatch.sv
// Routes MCU byte frames to one of four targets or returns interrupt status; MCU_DISPATCH_TIMEOUT_EN adds an idle-frame abort.
// Latency: target strobes/bytes and int_out_n 1 cycle, mcu_dout combinational; no backpressure.
module mcu_dispatch
    import mcu_dispatch_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mcu_strobe,
    input  logic        mcu_start,
    input  logic [7:0]  mcu_din,
    output logic [7:0]  mcu_dout,
    output logic [3:0]  tgt_strobe,
    output logic        tgt_start,
    output logic [7:0]  tgt_din,
    input  logic [31:0] tgt_dout,
    input  logic [3:0]  tgt_int_n,
    output logic        int_out_n
);
    state_t     state;
    logic [1:0] id;
    logic       payload;
    logic       expired;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    end

    assign payload = mcu_strobe && !mcu_start && (state == ST_SEL || state == ST_ROUTE);

`ifdef MCU_DISPATCH_TIMEOUT_EN
    logic active;
    assign active = (state == ST_SEL) || (state == ST_ROUTE) || (state == ST_STAT);

    mcu_dispatch_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (mcu_strobe || !active),
        .enable  (active),
        .expired (expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        mcu_dout = 8'h00;
        case (state)
            ST_SEL, ST_ROUTE: mcu_dout = tgt_dout[{id, 3'b000} +: 8];
            ST_STAT:          mcu_dout = {4'b0000, ~tgt_int_n};
            default:          mcu_dout = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            id         <= 2'd0;
            tgt_strobe <= 4'b0000;
            tgt_start  <= 1'b0;
            tgt_din    <= 8'h00;
            int_out_n  <= 1'b1;
        end else begin
            tgt_strobe <= 4'b0000;
            tgt_start  <= 1'b0;
            int_out_n  <= &tgt_int_n;
            // A start strobe always wins: it aborts any open frame with no stray target strobe.
            if (mcu_strobe && mcu_start) begin
                id <= mcu_din[1:0];
                if (mcu_din <= TGT_SDC) begin
                    state <= ST_SEL;
                end else if (mcu_din == TGT_STAT) begin
                    state <= ST_STAT;
                end else begin
                    state <= ST_DROP;
                end
            end else if (payload) begin
                tgt_strobe <= tgt_onehot(id);
                tgt_start  <= (state == ST_SEL);
                tgt_din    <= mcu_din;
                state      <= ST_ROUTE;
            end else if (expired) begin
                state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_mcu_dispatch.sv
// Directed bench for mcu_dispatch with hand-computed expectations.
module tb_mcu_dispatch;
    logic        clk = 1'b0;
    logic        reset;
    logic        mcu_strobe;
    logic        mcu_start;
    logic [7:0]  mcu_din;
    logic [7:0]  mcu_dout;
    logic [3:0]  tgt_strobe;
    logic        tgt_start;
    logic [7:0]  tgt_din;
    logic [31:0] tgt_dout;
    logic [3:0]  tgt_int_n;
    logic        int_out_n;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mcu_dispatch #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mcu_strobe (mcu_strobe),
        .mcu_start  (mcu_start),
        .mcu_din    (mcu_din),
        .mcu_dout   (mcu_dout),
        .tgt_strobe (tgt_strobe),
        .tgt_start  (tgt_start),
        .tgt_din    (tgt_din),
        .tgt_dout   (tgt_dout),
        .tgt_int_n  (tgt_int_n),
        .int_out_n  (int_out_n)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; presents one strobed byte for one cycle.
    task automatic send(input logic st, input logic [7:0] d);
        mcu_strobe = 1'b1;
        mcu_start  = st;
        mcu_din    = d;
        @(posedge clk);
        #1;
        mcu_strobe = 1'b0;
        mcu_start  = 1'b0;
        mcu_din    = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_tgt(input string tag, input logic [3:0] s, input logic st, input logic [7:0] d);
        chk({tag, ".strobe"}, 32'(tgt_strobe), 32'(s));
        chk({tag, ".start"},  32'(tgt_start),  32'(st));
        chk({tag, ".din"},    32'(tgt_din),    32'(d));
    endtask

    initial begin
        reset      = 1'b1;
        mcu_strobe = 1'b0;
        mcu_start  = 1'b0;
        mcu_din    = 8'h00;
        tgt_dout   = 32'hA1_5C_B2_C3;
        tgt_int_n  = 4'hF;
        idle(2);
        chk_tgt("rst", 4'b0000, 1'b0, 8'h00);
        chk("rst.int_out_n", 32'(int_out_n), 32'd1);
        chk("rst.mcu_dout",  32'(mcu_dout),  32'h00);
        reset = 1'b0;
        idle(1);

        // Frame to target 0 with three payload bytes.
        send(1'b1, 8'h00);
        chk("t0.sel.strobe", 32'(tgt_strobe), 32'h0);
        chk("t0.sel.dout",   32'(mcu_dout),   32'hC3);
        send(1'b0, 8'h04);
        chk_tgt("t0.b0", 4'b0001, 1'b1, 8'h04);
        idle(1);
        chk("t0.pulse", 32'(tgt_strobe), 32'h0);
        send(1'b0, 8'h43);
        chk_tgt("t0.b1", 4'b0001, 1'b0, 8'h43);
        send(1'b0, 8'h01);
        chk_tgt("t0.b2", 4'b0001, 1'b0, 8'h01);

        // Target 2 readback, start without strobe is ignored, then a dropped frame.
        send(1'b1, 8'h02);
        chk("t2.sel.dout", 32'(mcu_dout), 32'h5C);
        send(1'b0, 8'hAA);
        chk_tgt("t2.b0", 4'b0100, 1'b1, 8'hAA);
        chk("t2.route.dout", 32'(mcu_dout), 32'h5C);
        mcu_start = 1'b1;
        mcu_din   = 8'h07;
        idle(1);
        mcu_start = 1'b0;
        chk("nostrobe.strobe", 32'(tgt_strobe), 32'h0);
        chk("nostrobe.dout",   32'(mcu_dout),   32'h5C);
        send(1'b1, 8'h07);
        chk("drop.dout",   32'(mcu_dout),   32'h00);
        chk("drop.strobe", 32'(tgt_strobe), 32'h0);
        send(1'b0, 8'h55);
        chk("drop.byte.strobe", 32'(tgt_strobe), 32'h0);

        // Status frame and interrupt aggregation.
        tgt_int_n = 4'b1010;
        #1;
        chk("int.before", 32'(int_out_n), 32'd1);
        send(1'b1, 8'hFF);
        chk("stat.dout",  32'(mcu_dout),  32'h05);
        chk("stat.int",   32'(int_out_n), 32'd0);
        send(1'b0, 8'h12);
        chk("stat.byte.strobe", 32'(tgt_strobe), 32'h0);
        tgt_int_n = 4'hF;
        idle(1);
        chk("int.clear", 32'(int_out_n), 32'd1);

        // Mid-frame restart from target 1 to target 3.
        send(1'b1, 8'h01);
        send(1'b0, 8'h11);
        chk_tgt("t1.b0", 4'b0010, 1'b1, 8'h11);
        send(1'b1, 8'h03);
        chk("restart.strobe", 32'(tgt_strobe), 32'h0);
        chk("restart.dout",   32'(mcu_dout),   32'hA1);
        send(1'b0, 8'h22);
        chk_tgt("t3.b0", 4'b1000, 1'b1, 8'h22);

        // Idle open frame in SEL.
        send(1'b1, 8'h00);
        idle(18);
`ifdef MCU_DISPATCH_TIMEOUT_EN
        chk("tmo.dout", 32'(mcu_dout), 32'h00);
        send(1'b0, 8'h33);
        chk_tgt("tmo.byte", 4'b0000, 1'b0, 8'h22);
`else
        chk("tmo.dout", 32'(mcu_dout), 32'hC3);
        send(1'b0, 8'h33);
        chk_tgt("tmo.byte", 4'b0001, 1'b1, 8'h33);
`endif

        // Reset between target bytes.
        send(1'b1, 8'h02);
        send(1'b0, 8'h44);
        chk_tgt("pre.b0", 4'b0100, 1'b1, 8'h44);
        tgt_int_n = 4'b1110;
        send(1'b0, 8'h45);
        chk_tgt("pre.b1", 4'b0100, 1'b0, 8'h45);
        chk("pre.int", 32'(int_out_n), 32'd0);
        reset = 1'b1;
        #1;
        chk_tgt("arst", 4'b0000, 1'b0, 8'h00);
        chk("arst.int",  32'(int_out_n), 32'd1);
        chk("arst.dout", 32'(mcu_dout),  32'h00);
        tgt_int_n = 4'hF;
        idle(1);
        reset = 1'b0;
        idle(1);
        send(1'b0, 8'h46);
        chk_tgt("post.byte", 4'b0000, 1'b0, 8'h00);
        chk("post.dout", 32'(mcu_dout), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mcu_dispatch.md
MCU_DISPATCH -- requirements
Module: mcu_dispatch

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all logic on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: mcu_strobe  input  1  one-cycle pulse per byte received from MCU.
REQ-004 SHALL have port: mcu_start  input  1  qualifies mcu_strobe; marks the first byte of a frame.
REQ-005 SHALL have port: mcu_din  input  8  byte from MCU, valid with mcu_strobe.
REQ-006 SHALL have port: mcu_dout  output  8  reply byte to MCU.
REQ-007 SHALL have port: tgt_strobe  output  4  per-target byte strobe, one-hot or zero.
REQ-008 SHALL have port: tgt_start  output  1  shared; high with the first forwarded byte of a frame.
REQ-009 SHALL have port: tgt_din  output  8  shared forwarded byte.
REQ-010 SHALL have port: tgt_dout  input  32  reply bytes; target n on bits [8n+7:8n].
REQ-011 SHALL have port: tgt_int_n  input  4  active-low interrupt request per target.
REQ-012 SHALL have port: int_out_n  output  1  active-low aggregated interrupt to MCU.
REQ-013 SHALL have parameter: TIMEOUT_CYCLES, default 65535, idle cycles before an open frame is aborted.

Function
REQ-014 SHALL implement states IDLE, SEL, ROUTE, STAT and DROP.
REQ-015 SHALL, on mcu_strobe&&mcu_start in any state, latch mcu_din as target id and go to SEL if id<=3, STAT if id==8'hFF, DROP otherwise.
REQ-016 SHALL, in SEL on mcu_strobe&&!mcu_start, assert tgt_strobe[id], tgt_start=1 and tgt_din=mcu_din one cycle later, then go to ROUTE.
REQ-017 SHALL, in ROUTE on mcu_strobe&&!mcu_start, assert tgt_strobe[id], tgt_start=0 and tgt_din=mcu_din one cycle later.
REQ-018 SHALL register tgt_strobe, tgt_start and tgt_din (fixed 1-cycle latency); tgt_strobe and tgt_start SHALL be 0 in all other cycles.
REQ-019 SHALL drive mcu_dout combinationally: tgt_dout byte of latched id in SEL/ROUTE; {4'b0000, ~tgt_int_n} in STAT; 8'h00 in IDLE/DROP.
REQ-020 SHALL ignore non-start strobes in IDLE, STAT and DROP (no target strobe).
REQ-021 SHALL treat a start strobe mid-frame as abort-and-restart; no strobe for the old target is issued that cycle.
REQ-022 SHALL drive int_out_n low when any tgt_int_n bit is low, registered with 1-cycle latency.
REQ-023 SHALL treat mcu_start without mcu_strobe as don't-care.

Reset
REQ-024 SHALL, while reset is high, force state=IDLE, id=0, tgt_strobe=0, tgt_start=0, tgt_din=8'h00, int_out_n=1, timeout counter=0.
REQ-025 SHALL abort any open frame on reset without emitting further target strobes.

Configuration
REQ-026 SHALL, with MCU_DISPATCH_TIMEOUT_EN defined, count clk cycles without mcu_strobe in SEL/ROUTE/STAT and return to IDLE when the count reaches TIMEOUT_CYCLES; any strobe clears the counter.
REQ-027 SHALL, without MCU_DISPATCH_TIMEOUT_EN, omit the counter; frames stay open until the next start strobe or reset.

Structure
REQ-028 SHALL take state encoding and target-id constants (TGT_SYS=0, TGT_HID=1, TGT_OSD=2, TGT_SDC=3, TGT_STAT=8'hFF) from shared package mcu_dispatch_pkg.
REQ-029 SHALL place the timeout counter in sub-module mcu_dispatch_timer (clear, enable, expired), instantiated only under MCU_DISPATCH_TIMEOUT_EN.

Verification
REQ-030 SHALL cover: start 8'h00, bytes 8'h04,8'h43,8'h01 -> tgt_strobe 4'b0001 three times, tgt_start only with 8'h04, each 1 cycle after its mcu_strobe.
REQ-031 SHALL cover: start 8'h02, tgt_dout[23:16]=8'h5C -> mcu_dout=8'h5C in SEL/ROUTE; start 8'h07 -> DROP, mcu_dout=8'h00, no tgt_strobe.
REQ-032 SHALL cover: tgt_int_n=4'b1010, start 8'hFF -> mcu_dout=8'h05, int_out_n=0 one cycle after stimulus.
REQ-033 SHALL cover: frame to target 1, then start 8'h03 after one payload byte -> next byte gives tgt_strobe=4'b1000 with tgt_start=1.
REQ-034 SHALL cover: TIMEOUT_CYCLES=16, macro defined, SEL idle 16 cycles -> IDLE, subsequent non-start byte ignored; macro undefined -> byte forwarded with tgt_start=1.
REQ-035 SHALL cover: reset asserted between tgt bytes -> outputs at reset values immediately, next non-start byte ignored.
